// File: rtl/sequenciador_leds.sv
// LED sequence player: shows answer-memory entries 0..nivel, each lit for T_ON
// cycles followed by a T_OFF dark gap, then pulses pronto for one cycle.
module sequenciador_leds #(
   parameter int T_ON  = 3,
   parameter int T_OFF = 2
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       iniciar,
   input  logic       abortar,
   input  logic [3:0] nivel,
   input  logic [3:0] dado_memoria,
   output logic [3:0] endereco,
   output logic [3:0] leds,
   output logic       ativo,
   output logic       pronto,
   output logic [2:0] db_estado
);

   localparam int T_MAX = (T_ON > T_OFF) ? T_ON : T_OFF;
   localparam int TW    = (T_MAX > 1) ? $clog2(T_MAX) : 1;
   localparam logic [TW-1:0] T_ON_LAST  = TW'(T_ON - 1);
   localparam logic [TW-1:0] T_OFF_LAST = TW'(T_OFF - 1);

   typedef enum logic [2:0] {
      OCIOSO  = 3'd0,
      LIGA    = 3'd1,
      DESLIGA = 3'd2,
      AVANCA  = 3'd3,
      FIM     = 3'd4
   } estado_t;

   estado_t       estado_r, estado_s;
   logic [TW-1:0] timer_r, timer_s;
   logic [3:0]    endereco_r, endereco_s;
   logic [3:0]    nivel_r, nivel_s;
   logic          liga_r, ativo_r, pronto_r;
   logic [2:0]    db_estado_r;

   // Next-state logic; abortar overrides every state and timer event
   always_comb begin
      estado_s   = estado_r;
      timer_s    = timer_r;
      endereco_s = endereco_r;
      nivel_s    = nivel_r;
      if (abortar) begin
         estado_s   = OCIOSO;
         timer_s    = '0;
         endereco_s = 4'd0;
      end else begin
         case (estado_r)
            OCIOSO: begin
               timer_s    = '0;
               endereco_s = 4'd0;
               if (iniciar) begin
                  nivel_s  = nivel;
                  estado_s = LIGA;
               end else begin
                  estado_s = OCIOSO;
               end
            end
            LIGA: begin
               if (timer_r == T_ON_LAST) begin
                  timer_s  = '0;
                  estado_s = DESLIGA;
               end else begin
                  timer_s  = timer_r + TW'(1);
               end
            end
            DESLIGA: begin
               if (timer_r == T_OFF_LAST) begin
                  timer_s = '0;
                  if (endereco_r == nivel_r) begin
                     estado_s = FIM;
                  end else begin
                     estado_s = AVANCA;
                  end
               end else begin
                  timer_s = timer_r + TW'(1);
               end
            end
            AVANCA: begin
               timer_s    = '0;
               endereco_s = endereco_r + 4'd1;
               estado_s   = LIGA;
            end
            FIM: begin
               timer_s    = '0;
               endereco_s = 4'd0;
               estado_s   = OCIOSO;
            end
            default: begin
               timer_s    = '0;
               endereco_s = 4'd0;
               estado_s   = OCIOSO;
            end
         endcase
      end
   end

   // State, datapath and Moore output registers (outputs decoded from next state)
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         estado_r    <= OCIOSO;
         timer_r     <= '0;
         endereco_r  <= 4'd0;
         nivel_r     <= 4'd0;
         liga_r      <= 1'b0;
         ativo_r     <= 1'b0;
         pronto_r    <= 1'b0;
         db_estado_r <= 3'd0;
      end else begin
         estado_r    <= estado_s;
         timer_r     <= timer_s;
         endereco_r  <= endereco_s;
         nivel_r     <= nivel_s;
         liga_r      <= (estado_s == LIGA);
         ativo_r     <= (estado_s == LIGA) || (estado_s == DESLIGA) || (estado_s == AVANCA);
         pronto_r    <= (estado_s == FIM);
         db_estado_r <= estado_s;
      end
   end

   assign endereco  = endereco_r;
   assign leds      = liga_r ? dado_memoria : 4'b0000;
   assign ativo     = ativo_r;
   assign pronto    = pronto_r;
   assign db_estado = db_estado_r;

endmodule

// File: tb/tb_sequenciador_leds.sv
// Directed bench for sequenciador_leds (T_ON=3, T_OFF=2): one entry = 6 cycles
// including the AVANCA or FIM cycle; memory model returns endereco ^ 4'hA.
module tb_sequenciador_leds;

   logic       clock;
   logic       reset;
   logic       iniciar;
   logic       abortar;
   logic [3:0] nivel;
   logic [3:0] dado_memoria;
   logic [3:0] endereco;
   logic [3:0] leds;
   logic       ativo;
   logic       pronto;
   logic [2:0] db_estado;

   int checks = 0;
   int errors = 0;

   sequenciador_leds #(.T_ON(3), .T_OFF(2)) dut (
      .clock        (clock),
      .reset        (reset),
      .iniciar      (iniciar),
      .abortar      (abortar),
      .nivel        (nivel),
      .dado_memoria (dado_memoria),
      .endereco     (endereco),
      .leds         (leds),
      .ativo        (ativo),
      .pronto       (pronto),
      .db_estado    (db_estado)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   assign dado_memoria = endereco ^ 4'hA;

   task automatic chk(input string tag, input int cyc, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic chk_idle(input string tag, input int cyc);
      chk({tag, "_estado"}, cyc, 32'(db_estado), 32'd0);
      chk({tag, "_leds"},   cyc, 32'(leds),      32'd0);
      chk({tag, "_end"},    cyc, 32'(endereco),  32'd0);
      chk({tag, "_ativo"},  cyc, 32'(ativo),     32'd0);
      chk({tag, "_pronto"}, cyc, 32'(pronto),    32'd0);
   endtask

   // Full run of nivel n; cycle c is the cycle after edge c (edge 0 samples iniciar).
   task automatic run_seq(input int n, input bit disturb);
      int         total;
      int         e;
      int         p;
      logic [2:0] exp_st;
      logic [3:0] exp_leds;
      int         pronto_cyc;
      pronto_cyc = -1;
      total      = (n + 1) * 6;
      nivel      = 4'(n);
      iniciar    = 1'b1;
      @(negedge clock);
      iniciar    = 1'b0;
      for (int c = 1; c <= total + 1; c++) begin
         if (c > 1) @(negedge clock);
         if (c == total + 1) begin
            exp_st = 3'd0; e = 0;
         end else if (c == total) begin
            exp_st = 3'd4; e = n;
         end else begin
            e = (c - 1) / 6;
            p = (c - 1) % 6;
            exp_st = (p < 3) ? 3'd1 : ((p < 5) ? 3'd2 : 3'd3);
         end
         exp_leds = (exp_st == 3'd1) ? (4'(e) ^ 4'hA) : 4'd0;
         chk("estado", c, 32'(db_estado), 32'(exp_st));
         chk("end",    c, 32'(endereco),  32'(e));
         chk("leds",   c, 32'(leds),      32'(exp_leds));
         chk("ativo",  c, 32'(ativo),     32'((exp_st >= 3'd1) && (exp_st <= 3'd3)));
         chk("pronto", c, 32'(pronto),    32'(exp_st == 3'd4));
         if (pronto === 1'b1) pronto_cyc = c;
         if (disturb && c == 3) begin
            iniciar = 1'b1;
            nivel   = 4'd7;
         end
         if (disturb && c == 9) begin
            iniciar = 1'b0;
            nivel   = 4'(n);
         end
      end
      chk("pronto_cycle", n, 32'(pronto_cyc), 32'(total));
   endtask

   initial begin
      reset   = 1'b0;
      iniciar = 1'b0;
      abortar = 1'b0;
      nivel   = 4'd0;
      repeat (2) @(negedge clock);
      chk_idle("reset", 0);
      reset = 1'b1;
      repeat (3) @(negedge clock);
      chk_idle("idle", 0);

      // Single entry, then two idle cycles after completion
      run_seq(0, 1'b0);
      @(negedge clock);
      chk_idle("post0", 8);
      run_seq(2, 1'b0);
      run_seq(15, 1'b0);

      // Abort in cycle 4 of a nivel=3 run
      nivel   = 4'd3;
      iniciar = 1'b1;
      @(negedge clock);
      iniciar = 1'b0;
      repeat (3) @(negedge clock);
      chk("abort_pre_estado", 4, 32'(db_estado), 32'd2);
      abortar = 1'b1;
      @(negedge clock);
      abortar = 1'b0;
      chk_idle("abort4", 5);
      for (int c = 6; c <= 30; c++) begin
         @(negedge clock);
         chk("abort4_nopronto", c, 32'(pronto), 32'd0);
         chk("abort4_estado",   c, 32'(db_estado), 32'd0);
      end

      // Abort in AVANCA-following LIGA where endereco is already 1
      nivel   = 4'd3;
      iniciar = 1'b1;
      @(negedge clock);
      iniciar = 1'b0;
      repeat (7) @(negedge clock);
      chk("abort8_pre_end", 8, 32'(endereco), 32'd1);
      abortar = 1'b1;
      iniciar = 1'b1;
      @(negedge clock);
      abortar = 1'b0;
      iniciar = 1'b0;
      chk_idle("abort8", 9);

      // Re-pulsed iniciar and nivel 1->7 during a run are ignored
      run_seq(1, 1'b1);
      repeat (3) @(negedge clock);
      chk_idle("post_disturb", 16);

      // Asynchronous reset mid-LIGA, checked between clock edges
      nivel   = 4'd2;
      iniciar = 1'b1;
      @(negedge clock);
      iniciar = 1'b0;
      @(negedge clock);
      chk("prereset_estado", 2, 32'(db_estado), 32'd1);
      #1 reset = 1'b0;
      #1;
      chk_idle("async_rst", 2);
      @(negedge clock);
      #1 reset = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clock);
         chk_idle("after_rst", c);
      end
      run_seq(0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
